// File: rtl/retire_trace_buffer_if.sv
// Commit-side capture inputs, trace record stream and status flags of the retire trace buffer.
// master = cpu/consumer side, slave = the buffer itself.
interface retire_trace_buffer_if #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
);
    localparam int FW = $clog2(DEPTH) + 1;

    logic             capture_en;
    logic [15:0]      pc;
    logic             reg_write;
    logic [3:0]       write_reg;
    logic [15:0]      write_data;
    logic             mem_read;
    logic             mem_write;
    logic [15:0]      mem_addr;
    logic [15:0]      mem_data;
    logic             hlt;
    logic             evt_valid;
    logic             evt_ready;
    logic [15:0]      evt_inum;
    logic [15:0]      evt_pc;
    logic [1:0]       evt_kind;
    logic [3:0]       evt_reg;
    logic [15:0]      evt_value;
    logic [15:0]      evt_addr;
    logic             evt_halt;
    logic             halted;
    logic             overflow;
    logic [15:0]      dropped_count;
    logic [CNT_W-1:0] cycle_count;
    logic [FW-1:0]    fill;

    modport master (
        output capture_en, pc, reg_write, write_reg, write_data, mem_read, mem_write,
               mem_addr, mem_data, hlt, evt_ready,
        input  evt_valid, evt_inum, evt_pc, evt_kind, evt_reg, evt_value, evt_addr,
               evt_halt, halted, overflow, dropped_count, cycle_count, fill
    );

    modport slave (
        input  capture_en, pc, reg_write, write_reg, write_data, mem_read, mem_write,
               mem_addr, mem_data, hlt, evt_ready,
        output evt_valid, evt_inum, evt_pc, evt_kind, evt_reg, evt_value, evt_addr,
               evt_halt, halted, overflow, dropped_count, cycle_count, fill
    );
endinterface

// File: rtl/retire_trace_buffer.sv
// Retirement monitor: classifies each committed instruction, numbers it and queues the
// record in a FIFO that drains over a valid/ready stream.
module retire_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    retire_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    typedef struct packed {
        logic        halt;
        logic [1:0]  kind;
        logic [3:0]  rd;
        logic [15:0] value;
        logic [15:0] addr;
        logic [15:0] pc;
        logic [15:0] inum;
    } rec_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    rec_t             r_mem [DEPTH];
    rec_t             w_rec;
    rec_t             w_head;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [FW-1:0]    r_fill;
    logic [15:0]      r_inum;
    logic [15:0]      r_dropped;
    logic             r_overflow;
    logic [CNT_W-1:0] r_cycle;
    logic             w_capture;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;

    assign w_capture = bus.capture_en & (r_state == ST_RUN);
    assign w_pop     = (r_fill != '0) & bus.evt_ready;
    assign w_full    = (r_fill == FW'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push    = w_capture & (~w_full | w_pop);
    assign w_drop    = w_capture & ~w_push;

    always_comb begin
        w_rec      = '0;
        w_rec.pc   = bus.pc;
        w_rec.inum = r_inum;
        if (bus.hlt) begin
            w_rec.halt = 1'b1;
            w_rec.kind = 2'd0;
        end else if (bus.mem_write) begin
            w_rec.kind  = 2'd3;
            w_rec.value = bus.mem_data;
            w_rec.addr  = bus.mem_addr;
        end else if (bus.reg_write && bus.mem_read) begin
            w_rec.kind  = 2'd2;
            w_rec.rd    = bus.write_reg;
            w_rec.value = bus.write_data;
            w_rec.addr  = bus.mem_addr;
        end else if (bus.reg_write) begin
            w_rec.kind  = 2'd1;
            w_rec.rd    = bus.write_reg;
            w_rec.value = bus.write_data;
        end else begin
            w_rec.kind = 2'd0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_capture && bus.hlt) begin
                    w_state_next = ST_HALTED;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_inum     <= 16'h0000;
            r_dropped  <= 16'h0000;
            r_overflow <= 1'b0;
            r_cycle    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_cycle <= r_cycle + CNT_W'(1);
            // Dropped captures still consume a number so gaps reveal the loss downstream.
            if (w_capture) begin
                r_inum <= r_inum + 16'd1;
            end
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_rec;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + FW'(1);
            end else if (w_pop && !w_push) begin
                r_fill <= r_fill - FW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropped != 16'hFFFF) begin
                    r_dropped <= r_dropped + 16'd1;
                end
            end
        end
    end

    assign w_head            = r_mem[r_rd_ptr];
    assign bus.evt_valid     = (r_fill != '0);
    assign bus.evt_inum      = w_head.inum;
    assign bus.evt_pc        = w_head.pc;
    assign bus.evt_kind      = w_head.kind;
    assign bus.evt_reg       = w_head.rd;
    assign bus.evt_value     = w_head.value;
    assign bus.evt_addr      = w_head.addr;
    assign bus.evt_halt      = w_head.halt;
    assign bus.halted        = (r_state == ST_HALTED);
    assign bus.overflow      = r_overflow;
    assign bus.dropped_count = r_dropped;
    assign bus.cycle_count   = r_cycle;
    assign bus.fill          = r_fill;
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: capture, classification, overflow, halt, reset and stall.
module tb_retire_trace_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [70:0] got;
    logic [70:0] exp;

    retire_trace_buffer_if #(.DEPTH(16), .CNT_W(32)) bus ();

    retire_trace_buffer #(.DEPTH(16), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cap(input logic [15:0] pc, input logic rw, input logic [3:0] wr,
                       input logic [15:0] wd, input logic mr, input logic mw,
                       input logic [15:0] ma, input logic [15:0] md, input logic h);
        bus.capture_en = 1'b1;
        bus.pc         = pc;
        bus.reg_write  = rw;
        bus.write_reg  = wr;
        bus.write_data = wd;
        bus.mem_read   = mr;
        bus.mem_write  = mw;
        bus.mem_addr   = ma;
        bus.mem_data   = md;
        bus.hlt        = h;
    endtask

    task automatic idle();
        bus.capture_en = 1'b0;
        bus.pc         = 16'h0000;
        bus.reg_write  = 1'b0;
        bus.write_reg  = 4'h0;
        bus.write_data = 16'h0000;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = 16'h0000;
        bus.mem_data   = 16'h0000;
        bus.hlt        = 1'b0;
    endtask

    // Ends on a negedge just after release, so cycle_count there is 0.
    task automatic do_reset();
        @(negedge clk);
        idle();
        bus.evt_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic grab();
        got = {bus.evt_inum, bus.evt_pc, bus.evt_kind, bus.evt_reg,
               bus.evt_value, bus.evt_addr, bus.evt_halt};
    endtask

    task automatic test_reset();
        idle();
        bus.evt_ready = 1'b0;
        @(negedge clk);
        grab();
        checks++;
        if (got !== 71'h0) begin errors++; $display("FAIL reset_fields got=%h want=0", got); end
        checks++;
        if ({bus.evt_valid, bus.halted, bus.overflow} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b want=000", {bus.evt_valid, bus.halted, bus.overflow});
        end
        checks++;
        if (bus.fill !== 5'd0 || bus.dropped_count !== 16'd0 || bus.cycle_count !== 32'd0) begin
            errors++; $display("FAIL reset_counts fill=%0d drop=%0d cyc=%0d want 0/0/0",
                               bus.fill, bus.dropped_count, bus.cycle_count);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.cycle_count !== 32'd3) begin errors++; $display("FAIL cycle_run got=%0d want=3", bus.cycle_count); end
    endtask

    task automatic test_basic();
        do_reset();
        bus.evt_ready = 1'b1;
        checks++;
        if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_valid got=%b want=0", bus.evt_valid); end
        cap(16'h0000, 1'b1, 4'd3, 16'h0005, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.evt_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got=%b want=1", bus.evt_valid); end
        grab(); exp = {16'd0, 16'h0000, 2'd1, 4'd3, 16'h0005, 16'h0000, 1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL basic_alu got=%h want=%h", got, exp); end
        cap(16'h0002, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h0005, 1'b0);
        @(negedge clk);
        grab(); exp = {16'd1, 16'h0002, 2'd3, 4'd0, 16'h0005, 16'h0010, 1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL basic_store got=%h want=%h", got, exp); end
        cap(16'h0004, 1'b1, 4'd4, 16'h0005, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        @(negedge clk);
        grab(); exp = {16'd2, 16'h0004, 2'd2, 4'd4, 16'h0005, 16'h0010, 1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL basic_load got=%h want=%h", got, exp); end
        cap(16'h0006, 1'b1, 4'd7, 16'h1111, 1'b0, 1'b1, 16'h0020, 16'h2222, 1'b0);
        @(negedge clk);
        grab(); exp = {16'd3, 16'h0006, 2'd3, 4'd0, 16'h2222, 16'h0020, 1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL basic_store_prio got=%h want=%h", got, exp); end
        cap(16'h0008, 1'b0, 4'd5, 16'h3333, 1'b1, 1'b0, 16'h0030, 16'h0044, 1'b0);
        @(negedge clk);
        grab(); exp = {16'd4, 16'h0008, 2'd0, 4'd0, 16'h0000, 16'h0000, 1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL basic_nop got=%h want=%h", got, exp); end
        idle();
        @(negedge clk);
        checks++;
        if (bus.evt_valid !== 1'b0 || bus.fill !== 5'd0) begin
            errors++; $display("FAIL basic_drained valid=%b fill=%0d want 0/0", bus.evt_valid, bus.fill);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cap(16'(2 * i), 1'b1, 4'd1, 16'(i), 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
            @(negedge clk);
        end
        idle();
        checks++;
        if (bus.fill !== 5'd16) begin errors++; $display("FAIL ovf_fill got=%0d want=16", bus.fill); end
        checks++;
        if (bus.overflow !== 1'b1 || bus.dropped_count !== 16'd4) begin
            errors++; $display("FAIL ovf_drop ovf=%b drop=%0d want 1/4", bus.overflow, bus.dropped_count);
        end
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            grab(); exp = {16'(i), 16'(2 * i), 2'd1, 4'd1, 16'(i), 16'h0000, 1'b0};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL ovf_drain_%0d got=%h want=%h", i, got, exp); end
            @(negedge clk);
        end
        checks++;
        if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b want=0", bus.evt_valid); end
        cap(16'h0050, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        idle();
        checks++;
        if (bus.evt_inum !== 16'd20) begin errors++; $display("FAIL ovf_next_inum got=%0d want=20", bus.evt_inum); end
        @(negedge clk);
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cap(16'(2 * i), 1'b1, 4'd1, 16'(i), 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
            @(negedge clk);
        end
        checks++;
        if (bus.fill !== 5'd16) begin errors++; $display("FAIL full_fill got=%0d want=16", bus.fill); end
        cap(16'h0100, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        bus.evt_ready = 1'b1;
        @(negedge clk);
        idle();
        checks++;
        if (bus.fill !== 5'd16 || bus.dropped_count !== 16'd0 || bus.overflow !== 1'b0) begin
            errors++; $display("FAIL full_pop_push fill=%0d drop=%0d ovf=%b want 16/0/0",
                               bus.fill, bus.dropped_count, bus.overflow);
        end
        checks++;
        if (bus.evt_inum !== 16'd1) begin errors++; $display("FAIL full_head got=%0d want=1", bus.evt_inum); end
        repeat (15) @(negedge clk);
        checks++;
        if ({bus.evt_inum, bus.evt_pc} !== {16'd16, 16'h0100}) begin
            errors++; $display("FAIL full_last got=%h want=%h", {bus.evt_inum, bus.evt_pc}, {16'd16, 16'h0100});
        end
        @(negedge clk);
        checks++;
        if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL full_empty got=%b want=0", bus.evt_valid); end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cap(16'(2 * i), 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
            @(negedge clk);
        end
        checks++;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_pre got=%b want=0", bus.halted); end
        cap(16'h001A, 1'b1, 4'd2, 16'h0099, 1'b0, 1'b1, 16'h0040, 16'h0077, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.halted !== 1'b1 || bus.fill !== 5'd8) begin
            errors++; $display("FAIL halt_state halted=%b fill=%0d want 1/8", bus.halted, bus.fill);
        end
        for (int i = 0; i < 3; i++) begin
            cap(16'h0200, 1'b1, 4'd6, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
            @(negedge clk);
        end
        idle();
        checks++;
        if (bus.fill !== 5'd8) begin errors++; $display("FAIL halt_frozen fill got=%0d want=8", bus.fill); end
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            grab();
            if (i == 7) exp = {16'd7, 16'h001A, 2'd0, 4'd0, 16'h0000, 16'h0000, 1'b1};
            else        exp = {16'(i), 16'(2 * i), 2'd0, 4'd0, 16'h0000, 16'h0000, 1'b0};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL halt_drain_%0d got=%h want=%h", i, got, exp); end
            @(negedge clk);
        end
        checks++;
        if (bus.evt_valid !== 1'b0 || bus.halted !== 1'b1) begin
            errors++; $display("FAIL halt_end valid=%b halted=%b want 0/1", bus.evt_valid, bus.halted);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cap(16'(4 * i), 1'b1, 4'd8, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
            @(negedge clk);
        end
        idle();
        checks++;
        if (bus.fill !== 5'd5) begin errors++; $display("FAIL ares_pre_fill got=%0d want=5", bus.fill); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.evt_valid !== 1'b0 || bus.fill !== 5'd0 || bus.cycle_count !== 32'd0) begin
            errors++; $display("FAIL ares_immediate valid=%b fill=%0d cyc=%0d want 0/0/0",
                               bus.evt_valid, bus.fill, bus.cycle_count);
        end
        rst = 1'b0;
        @(negedge clk);
        cap(16'h0300, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        idle();
        checks++;
        if (bus.evt_inum !== 16'd0 || bus.fill !== 5'd1) begin
            errors++; $display("FAIL ares_next inum=%0d fill=%0d want 0/1", bus.evt_inum, bus.fill);
        end
    endtask

    task automatic test_stall();
        do_reset();
        cap(16'h0042, 1'b1, 4'd9, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        idle();
        checks++;
        if (bus.cycle_count !== 32'd1) begin errors++; $display("FAIL stall_cyc0 got=%0d want=1", bus.cycle_count); end
        exp = {16'd0, 16'h0042, 2'd1, 4'd9, 16'hBEEF, 16'h0000, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            grab();
            checks++;
            if (got !== exp || bus.evt_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold_%0d got=%h valid=%b want=%h valid=1", k, got, bus.evt_valid, exp);
            end
        end
        checks++;
        if (bus.cycle_count !== 32'd11) begin errors++; $display("FAIL stall_cyc10 got=%0d want=11", bus.cycle_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_halt();
        test_async_reset();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
